div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle controller and iterative datapath for the RV32M division instructions (DIV, DIVU, REM, REMU) issued by the decode stage. It latches operands on a start request, runs a 32-step restoring division, and holds the pipeline stalled until the result is ready. It then presents a one-cycle register-write result to writeback. Divide-by-zero and signed overflow follow the RISC-V specification without iterating. The block sits beside the execute stage, fed by the decode outputs (op1, op2, inst funct3, rd).

## Interface
- No parameters. Data width is fixed at 32.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start_i  in  1  decoded division instruction present this cycle.
- funct3_i  in  3  inst[14:12]. 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_i  in  32  dividend (rs1 data).
- op2_i  in  32  divisor (rs2 data).
- reg_wr_addr_i  in  5  destination rd.
- abort_i  in  1  pipeline flush (taken jump/branch); kills an in-flight operation.
- stall_o  out  1  hold fetch/decode; combinational.
- busy_o  out  1  registered; high in BUSY and DONE.
- reg_wr_en_o  out  1  one-cycle result-valid pulse.
- reg_wr_addr_o  out  5  latched rd.
- result_o  out  32  quotient or remainder; valid only while reg_wr_en_o=1, otherwise 0.

## Operation
- States are IDLE, BUSY and DONE. Reset enters IDLE. All outputs and internal registers reset to 0.
- **Accept:** in IDLE, start_i=1, funct3_i[2]=1 and abort_i=0.
  - Latch the operation, rd, |op1| and |op2|.
  - Absolute values are taken only for the signed ops (funct3_i[0]=0). Unsigned ops latch operands unchanged.
  - Latch neg_q = op1[31]^op2[31] and neg_r = op1[31], both signed ops only.
  - Latch special case: op2=0 → div-by-zero; signed op with op1=0x80000000 and op2=0xFFFFFFFF → overflow.
- **IDLE → DONE:** on an accepted special case.
- **IDLE → BUSY:** on any other accepted start. Load step counter with 0.
- **Ignored starts:** start_i with funct3_i[2]=0, or start_i outside IDLE.
- **BUSY step (one per cycle):**
  - Shift {rem,quo} left 1.
  - Trial = rem − divisor (33-bit). If non-negative, rem ← trial and quo[0] ← 1.
  - After step 31 (counter = 31), go to DONE.
- **DONE:** assert reg_wr_en_o with the result, then go to IDLE next cycle.
- **Result selection:**
  - Quotient ops (funct3[1]=0) return quo, negated if neg_q.
  - Remainder ops return rem, negated if neg_r.
  - Div-by-zero: quotient = 0xFFFFFFFF, remainder = op1 (original).
  - Overflow: quotient = 0x80000000, remainder = 0.
- **Abort:** abort_i in BUSY or DONE → IDLE next cycle, no reg_wr_en_o. In DONE the pulse is suppressed in that same cycle. In IDLE, abort_i blocks acceptance.

## Timing
- Normal latency: start accepted at edge 0, BUSY for edges 1–32, reg_wr_en_o high during cycle 33. busy_o is back low in cycle 34.
- Special case: reg_wr_en_o high in cycle 1.
- stall_o = (IDLE & accepted start) | BUSY. It is low in DONE, so decode advances in the same cycle writeback occurs.
- The next start may be accepted in the cycle after DONE (IDLE), giving back-to-back throughput of 34 cycles.
- Reset mid-operation: immediate return to IDLE, all outputs 0, latched operands discarded.
- Results are derived only from latched values. op1_i, op2_i and funct3_i may change after acceptance.

## Structure
- Shared package holds:
  - funct3 constants F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - OPCODE_OP (0110011) and FUNCT7_MULDIV (0000001).
  - State enum {IDLE, BUSY, DONE}.
- Sub-module div_step (combinational): inputs rem, quo, divisor; outputs next rem and quo for one restoring step.
- FSM, counter, sign fix-up and special-case muxing live in div_sequencer.

## Test plan
- DIVU op1=20, op2=3 → reg_wr_en_o in cycle 33 with result 6. REMU same operands → 2. stall_o high cycles 0–32.
- DIV op1=−7 (0xFFFFFFF9), op2=2 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIV op1=5, op2=0 → 0xFFFFFFFF in cycle 1. REMU 5/0 → 5. No BUSY cycles.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1. REM same → 0.
- DIVU 100/7 with abort_i at cycle 10 → no reg_wr_en_o, IDLE at cycle 11. A new DIVU 9/3 in cycle 11 returns 3 in cycle 44.
- rst_n low at cycle 15 of an operation → all outputs 0 immediately, no result pulse. start_i during BUSY is ignored (result unchanged).

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared constants and state type for the RV32M division sequencer.
// The opcode/funct7 values are provided for the decode stage.
package div_sequencer_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division step: shift {rem,quo} left and subtract the
// divisor from the partial remainder when it fits.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;

  // When the trial fits, the true difference is below 2^32, so a 32-bit subtract is exact.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    fits    = (shifted >= {1'b0, divisor_i});
    diff    = shifted[31:0] - divisor_i;
    rem_o   = fits ? diff : shifted[31:0];
    quo_o   = {quo_i[30:0], fits};
  end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: latches operands, runs 32 restoring
// steps, then issues a one-cycle writeback pulse.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  reg_wr_addr_i,
  input  logic        abort_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        reg_wr_en_o,
  output logic [4:0]  reg_wr_addr_o,
  output logic [31:0] result_o
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, quo_q, divisor_q;
  logic [4:0]  rd_q;
  logic        is_rem_q, neg_q_q, neg_r_q, div_zero_q, ovf_q;
  logic        busy_q;

  logic        accept, is_signed, div_zero, ovf;
  logic [31:0] abs_op1, abs_op2;
  logic [31:0] step_rem, step_quo;
  logic [31:0] quo_fix, rem_fix, result_sel;

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    accept    = (state_q == IDLE) & start_i & funct3_i[2] & ~abort_i;
    is_signed = ~funct3_i[0];
    abs_op1   = (is_signed & op1_i[31]) ? -op1_i : op1_i;
    abs_op2   = (is_signed & op2_i[31]) ? -op2_i : op2_i;
    div_zero  = (op2_i == 32'd0);
    ovf       = is_signed & (op1_i == 32'h8000_0000) & (op2_i == 32'hFFFF_FFFF);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (div_zero | ovf) ? DONE : BUSY;
      BUSY: begin
        if (abort_i)              state_d = IDLE;
        else if (cnt_q == 5'd31)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      cnt_q      <= 5'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      divisor_q  <= 32'd0;
      rd_q       <= 5'd0;
      is_rem_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        cnt_q      <= 5'd0;
        rem_q      <= 32'd0;
        quo_q      <= abs_op1;
        divisor_q  <= abs_op2;
        rd_q       <= reg_wr_addr_i;
        is_rem_q   <= funct3_i[1];
        neg_q_q    <= is_signed & (op1_i[31] ^ op2_i[31]);
        neg_r_q    <= is_signed & op1_i[31];
        div_zero_q <= div_zero;
        ovf_q      <= ovf;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 5'd1;
        rem_q <= step_rem;
        quo_q <= step_quo;
      end
    end
  end

  // On divide-by-zero no step runs, so neg_r applied to |op1| in quo_q restores the original op1.
  always_comb begin
    quo_fix = neg_q_q ? -quo_q : quo_q;
    rem_fix = neg_r_q ? -rem_q : rem_q;
    if (div_zero_q)
      result_sel = is_rem_q ? (neg_r_q ? -quo_q : quo_q) : 32'hFFFF_FFFF;
    else if (ovf_q)
      result_sel = is_rem_q ? 32'd0 : 32'h8000_0000;
    else
      result_sel = is_rem_q ? rem_fix : quo_fix;

    stall_o     = accept | (state_q == BUSY);
    reg_wr_en_o = (state_q == DONE) & ~abort_i;
    result_o    = reg_wr_en_o ? result_sel : 32'd0;
  end

  assign busy_o        = busy_q;
  assign reg_wr_addr_o = rd_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] op1_i = 32'd0;
  logic [31:0] op2_i = 32'd0;
  logic [4:0]  reg_wr_addr_i = 5'd0;
  logic        abort_i = 1'b0;
  logic        stall_o, busy_o, reg_wr_en_o;
  logic [4:0]  reg_wr_addr_o;
  logic [31:0] result_o;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  div_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .funct3_i      (funct3_i),
    .op1_i         (op1_i),
    .op2_i         (op2_i),
    .reg_wr_addr_i (reg_wr_addr_i),
    .abort_i       (abort_i),
    .stall_o       (stall_o),
    .busy_o        (busy_o),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_wr_addr_o (reg_wr_addr_o),
    .result_o      (result_o)
  );

  always #5 clk = ~clk;

  // RISC-V division semantics straight from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f3[1] ? 32'd0 : 32'h8000_0000;
    if (!f3[0]) begin
      sa = a;
      sb = b;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0 of the operation.
  // Returns #1 after the edge ending the last watched cycle.
  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                               input logic [31:0] exp_res, input int abort_at, input int junk_at);
    logic        stall_bad = 1'b0, busy_bad = 1'b0, res_bad = 1'b0;
    logic        exp_stall, exp_busy;
    int          wr_count = 0, wr_cycle = -1, last;
    logic [31:0] wr_res = 32'd0;
    logic [4:0]  wr_addr = 5'd0;
    last = (abort_at >= 0) ? abort_at : exp_lat;
    start_i = 1'b1; funct3_i = f3; op1_i = a; op2_i = b; reg_wr_addr_i = rd;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        start_i       = (c == junk_at);
        funct3_i      = (c == junk_at) ? F3_DIV : 3'($urandom);
        op1_i         = $urandom;
        op2_i         = $urandom;
        reg_wr_addr_i = 5'($urandom);
      end
      abort_i = (c == abort_at);
      @(negedge clk);
      exp_stall = (c == 0) || (exp_lat == 33 && c <= 32);
      exp_busy  = (c >= 1);
      if (stall_o !== exp_stall) stall_bad = 1'b1;
      if (busy_o !== exp_busy) busy_bad = 1'b1;
      if (reg_wr_en_o === 1'b1) begin
        wr_count++;
        wr_cycle = c;
        wr_res   = result_o;
        wr_addr  = reg_wr_addr_o;
      end else if (result_o !== 32'd0) res_bad = 1'b1;
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    checkOutput({name, " stall pattern"}, 32'(stall_bad), 32'd0);
    checkOutput({name, " busy pattern"}, 32'(busy_bad), 32'd0);
    checkOutput({name, " result zero when idle"}, 32'(res_bad), 32'd0);
    if (abort_at < 0) begin
      checkOutput({name, " pulse count"}, 32'(wr_count), 32'd1);
      checkOutput({name, " pulse cycle"}, 32'(wr_cycle), 32'(exp_lat));
      checkOutput({name, " result"}, wr_res, exp_res);
      checkOutput({name, " rd"}, 32'(wr_addr), 32'(rd));
    end else begin
      checkOutput({name, " no pulse after abort"}, 32'(wr_count), 32'd0);
    end
  endtask

  // A start that must not be accepted leaves the block idle.
  task automatic checkIgnored(input string name, input logic [2:0] f3, input logic abort);
    int activity = 0;
    start_i = 1'b1; funct3_i = f3; op1_i = 32'd20; op2_i = 32'd3; abort_i = abort;
    @(negedge clk);
    checkOutput({name, " stall"}, 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || reg_wr_en_o !== 1'b0) activity++;
      @(posedge clk); #1;
    end
    checkOutput({name, " stays idle"}, 32'(activity), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          sel, pulses;

    vecs.push_back('{"DIVU 20/3",        F3_DIVU, 32'd20,         32'd3,          32'd6,          33});
    vecs.push_back('{"REMU 20/3",        F3_REMU, 32'd20,         32'd3,          32'd2,          33});
    vecs.push_back('{"DIV -7/2",         F3_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{"REM -7/2",         F3_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{"DIVU fff9/2",      F3_DIVU, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33});
    vecs.push_back('{"DIV 5/0",          F3_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{"REMU 5/0",         F3_REMU, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{"REM -5/0",         F3_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1});
    vecs.push_back('{"DIV ovf",          F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{"REM ovf",          F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{"DIVU 8000/ffff",   F3_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
    vecs.push_back('{"REMU 8000/ffff",   F3_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
    vecs.push_back('{"DIV 7/-2",         F3_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
    vecs.push_back('{"REM 7/-2",         F3_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33});
    vecs.push_back('{"DIVU ffff/1",      F3_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
    vecs.push_back('{"DIV 8000/1",       F3_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  33});

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset stall", 32'(stall_o), 32'd0);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset wr_en", 32'(reg_wr_en_o), 32'd0);
    checkOutput("reset rd", 32'(reg_wr_addr_o), 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      applyStimulus(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1),
                    vecs[i].exp_lat, vecs[i].exp_res, -1, -1);

    applyStimulus("DIVU 100/7 abort@10", F3_DIVU, 32'd100, 32'd7, 5'd4, 33, 32'd14, 10, -1);
    applyStimulus("DIVU 9/3 after abort", F3_DIVU, 32'd9, 32'd3, 5'd5, 33, 32'd3, -1, -1);
    applyStimulus("DIV 5/0 abort in DONE", F3_DIV, 32'd5, 32'd0, 5'd6, 1, 32'hFFFF_FFFF, 1, -1);
    applyStimulus("DIVU 100/7 start in BUSY", F3_DIVU, 32'd100, 32'd7, 5'd7, 33, 32'd14, -1, 5);
    checkIgnored("start funct3=001", 3'b001, 1'b0);
    checkIgnored("start with abort", F3_DIVU, 1'b1);

    // Reset asserted during cycle 15 of an operation.
    start_i = 1'b1; funct3_i = F3_DIVU; op1_i = 32'd100; op2_i = 32'd7; reg_wr_addr_i = 5'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset stall", 32'(stall_o), 32'd0);
    checkOutput("mid reset busy", 32'(busy_o), 32'd0);
    checkOutput("mid reset wr_en", 32'(reg_wr_en_o), 32'd0);
    checkOutput("mid reset rd", 32'(reg_wr_addr_o), 32'd0);
    checkOutput("mid reset result", result_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (reg_wr_en_o !== 1'b0 || busy_o !== 1'b0) pulses++;
      @(posedge clk); #1;
    end
    checkOutput("no result after reset", 32'(pulses), 32'd0);

    for (int n = 0; n < 25; n++) begin
      rf3 = 3'(4 + $urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d f3=%b %h/%h", n, rf3, ra, rb), rf3, ra, rb, 5'($urandom),
                    ref_latency(rf3, ra, rb), ref_result(rf3, ra, rb), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
